rgb_led_arbiter: RTL and testbench
==================================

# rgb_led_arbiter

Shares the board's single active-low RGB LED among `N_REQ` requesters. Each requester asks for a colour and a display duration in milliseconds. A round-robin arbiter grants the LED to one requester at a time and holds that colour for exactly the requested time. Between grants, a blank gap keeps consecutive colours distinguishable. It sits between status sources (heartbeat, error, activity) and the `led[2:0]` pins.

## Interface
- `N_REQ`, 3: number of requesters, 2..8.
- `TICK_DIV`, 27000: `sys_clk` cycles per millisecond tick (27 MHz board clock).
- `GAP_MS`, 50: blank time after each grant, in ticks; 0 = no gap.
- `sys_clk`  in  1  clock.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  level request per requester.
- `req_color`  in  3*N_REQ  colour for requester i at `[3i+2:3i]`, active-high `{G,B,R}`.
- `req_ms`  in  16*N_REQ  hold time for requester i at `[16i+15:16i]`, in ticks.
- `gnt`  out  N_REQ  one-hot grant, high for the whole hold.
- `done`  out  N_REQ  one-cycle pulse on the granted bit when its hold completes.
- `busy`  out  1  high in HOLD and GAP.
- `led`  out  3  LED pins, active-low: 3'b110 R, 3'b101 B, 3'b011 G, 3'b111 off.

## Operation
- States: IDLE, HOLD, GAP.
- Prescaler counts 0..TICK_DIV-1 and emits a tick when it reaches TICK_DIV-1.
  - It is cleared on every entry to HOLD and GAP, so durations are exact.
  - Tick counter is 16 bits.
- IDLE:
  - `led` = 3'b111, `gnt` = 0.
  - If any `req` bit is high, select the first asserted index searching from `(last+1) mod N_REQ` upward with wrap.
  - Latch that requester's colour and ms value. An ms value of 0 is latched as 1.
  - Update `last` to the selected index, then go to HOLD.
- HOLD:
  - `gnt[last]` = 1, `led` = ~latched colour.
  - Inputs are ignored. A change or drop of `req`, `req_color` or `req_ms` does not alter the running hold.
  - When the tick count reaches the latched ms value: `done[last]` = 1 for one cycle.
  - Then go to GAP, or straight to IDLE if `GAP_MS` = 0.
- GAP:
  - `led` = 3'b111, `gnt` = 0.
  - After `GAP_MS` ticks, go to IDLE.
- Requesters are not queued. A requester whose `req` is low when IDLE arbitrates is skipped.
- A requester holding `req` high is re-granted only after all other asserted requesters have been served.
- Colour 3'b000 is legal and shows off while `gnt` is held.
- Reset values:
  - `led` = 3'b111, `gnt` = 0, `done` = 0, `busy` = 0, state = IDLE, prescaler and tick counter = 0.
  - `last` = N_REQ-1, so requester 0 has first priority.
- Reset mid-HOLD or mid-GAP: all outputs return to their reset values asynchronously. No `done` pulse is emitted.

## Timing
- `req` is sampled at an IDLE edge k. From edge k onward, `gnt`, `led` and `busy` are registered values.
- HOLD lasts exactly ms×TICK_DIV cycles.
- `done` is high in the first cycle after HOLD, the same edge at which `gnt` falls and `led` goes to 3'b111.
- GAP lasts exactly GAP_MS×TICK_DIV cycles. `busy` falls on entry to IDLE.
- IDLE lasts at least one cycle between grants.
  - Grant-to-grant spacing = (ms+GAP_MS)×TICK_DIV + 1 cycles.
  - With `GAP_MS` = 0 the spacing is ms×TICK_DIV + 1 cycles, and `done` coincides with the IDLE cycle.
- Arbitration is combinational on registered `last` plus `req`. There is one cycle from `req` sampled to `gnt` visible.
- Outputs are fully registered; `led` has no glitches.

## Test plan
Benches use `TICK_DIV`=4, `GAP_MS`=2, `N_REQ`=3 unless stated otherwise.
- **Single request:** `req`=001, colour 001 (R), ms=3. Expect `gnt`=001 and `led`=3'b110 for 12 cycles, then `done`=001 for one cycle, `led`=3'b111 for 8 cycles, then IDLE and an immediate re-grant if `req` is still high.
- **Round-robin:** `req`=111 held, ms=1 each. Expect grant order 0,1,2,0 and grant starts spaced 13 cycles apart.
- **Input changes during hold:** `req`=010, ms=5; drop `req` and change colour mid-HOLD. Expect the hold to complete with the original colour for 20 cycles and `done`=010.
- **Zero duration:** ms=0 behaves as ms=1, giving a 4-cycle hold. With `GAP_MS`=0, expect `done` in the IDLE cycle and a grant-to-grant spacing of 5 cycles.
- **Reset mid-operation:** assert `sys_rst_n`=0 mid-HOLD. Expect `led`=3'b111 and `gnt`=0 immediately with no `done`. After release with `req`=111, expect requester 0 granted first.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: round-robin sharing of one active-low RGB LED, each grant holds a colour
// for an exact number of ms ticks followed by a blank gap.
module rgb_led_arbiter #(
  parameter int N_REQ = 3,
  parameter int TICK_DIV = 27000,
  parameter int GAP_MS = 50
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [3*N_REQ-1:0]    req_color,
  input  logic [16*N_REQ-1:0]   req_ms,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [2:0]            led
);
  localparam int LW = $clog2(N_REQ);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [15:0] cnt, cnt_n, dur, dur_n;
  logic [2:0] col, col_n, led_n;
  logic [LW-1:0] last, last_n, sel, idx;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic tick, hold_end, gap_end;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign hold_end = state == HOLD && tick && cnt + 16'd1 == dur;
  assign gap_end = state == GAP && tick && cnt + 16'd1 == 16'(GAP_MS);
  // Scan from farthest to nearest so the nearest asserted index after last wins
  always_comb begin
    sel = last;
    idx = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = LW'((int'(last) + i) % N_REQ);
      if (req[idx]) sel = idx;
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && |req) state_n = HOLD;
    else if (hold_end) state_n = GAP_MS == 0 ? IDLE : GAP;
    else if (gap_end) state_n = IDLE;
  end
  // Outputs are computed from the next state and registered, so led never glitches
  always_comb begin
    last_n = state == IDLE && |req ? sel : last;
    col_n = state == IDLE ? req_color[3*sel +: 3] : col;
    dur_n = state != IDLE ? dur : req_ms[16*sel +: 16] == 16'd0 ? 16'd1 : req_ms[16*sel +: 16];
    pre_n = state_n != state || state == IDLE || tick ? '0 : pre + PW'(1);
    cnt_n = state_n != state || state == IDLE ? '0 : cnt + 16'(tick);
    gnt_n = state_n == HOLD ? N_REQ'(1) << last_n : '0;
    done_n = hold_end ? N_REQ'(1) << last : '0;
    led_n = state_n == HOLD ? ~col_n : 3'b111;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre <= '0;
      cnt <= '0;
      dur <= 16'd1;
      col <= '0;
      last <= LW'(N_REQ - 1);
      gnt <= '0;
      done <= '0;
      busy <= 1'b0;
      led <= 3'b111;
    end else begin
      pre <= pre_n;
      cnt <= cnt_n;
      dur <= dur_n;
      col <= col_n;
      last <= last_n;
      gnt <= gnt_n;
      done <= done_n;
      busy <= state_n != IDLE;
      led <= led_n;
    end
  end
endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: scoreboard bench; a monitor turns each grant+gap into a record and
// compares it against the expectation queue filled by the scenario tasks.
module tb_rgb_led_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] req = '0, req1 = '0;
  logic [8:0] color = '0, color1 = '0;
  logic [47:0] ms = '0, ms1 = '0;
  logic [2:0] gnt, done, led, gnt1, done1, led1;
  logic busy, busy1;
  int checks = 0, errors = 0, cyc = 0, starts = 0, bad_done = 0, ph = 0;
  typedef struct { logic [2:0] gnt; logic [2:0] led; int len; int gap; int start; bit done_ok; bit stable; } rec_t;
  rec_t cur, me;
  rec_t exp_q[$];
  int start_q[$];

  rgb_led_arbiter #(.N_REQ(3), .TICK_DIV(4), .GAP_MS(2)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req), .req_color(color), .req_ms(ms),
    .gnt(gnt), .done(done), .busy(busy), .led(led));
  rgb_led_arbiter #(.N_REQ(3), .TICK_DIV(4), .GAP_MS(0)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req1), .req_color(color1), .req_ms(ms1),
    .gnt(gnt1), .done(done1), .busy(busy1), .led(led1));

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one record per grant, closed when busy falls after the gap
  always @(negedge clk) begin
    if (!rst_n) ph = 0;
    else begin
      if (ph == 1 && gnt == 3'b000) begin
        cur.done_ok = done === cur.gnt;
        cur.gap = 0;
        ph = 2;
      end else if (done !== 3'b000) bad_done++;
      if (ph == 2) begin
        if (busy && gnt == 3'b000) begin
          cur.gap++;
          if (led !== 3'b111) cur.stable = 0;
        end else begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant gnt=%b len=%0d required no grant", cur.gnt, cur.len);
          end else begin
            me = exp_q.pop_front();
            if (cur.gnt !== me.gnt || cur.led !== me.led || cur.len != me.len || cur.gap != me.gap || !cur.done_ok || !cur.stable) begin
              errors++;
              $display("FAIL grant_record gnt=%b led=%b len=%0d gap=%0d done_ok=%0d stable=%0d required gnt=%b led=%b len=%0d gap=%0d done_ok=1 stable=1",
                       cur.gnt, cur.led, cur.len, cur.gap, cur.done_ok, cur.stable, me.gnt, me.led, me.len, me.gap);
            end
          end
          ph = 0;
        end
      end
      if (ph == 1) begin
        cur.len++;
        if (gnt !== cur.gnt || led !== cur.led || !busy) cur.stable = 0;
      end
      if (ph == 0 && gnt != 3'b000) begin
        cur.gnt = gnt;
        cur.led = led;
        cur.len = 1;
        cur.gap = 0;
        cur.start = cyc;
        cur.done_ok = 0;
        cur.stable = 1;
        start_q.push_back(cyc);
        starts++;
        ph = 1;
      end
    end
  end

  task automatic expect_rec(input logic [2:0] g, input logic [2:0] l, input int len, input int gap);
    rec_t r;
    r.gnt = g; r.led = l; r.len = len; r.gap = gap; r.start = 0; r.done_ok = 1; r.stable = 1;
    exp_q.push_back(r);
  endtask

  task automatic wait_starts(input int n, output bit ok);
    for (int i = 0; i < 300 && starts < n; i++) @(posedge clk);
    ok = starts >= n;
    #1;
  endtask

  task automatic wait_drained(output bit ok);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    ok = exp_q.size() == 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || done !== 3'b000 || busy !== 1'b0 || led !== 3'b111) begin
      errors++;
      $display("FAIL reset_values gnt=%b done=%b busy=%b led=%b required 000 000 0 111", gnt, done, busy, led);
    end
    checks++;
    if (gnt1 !== 3'b000 || done1 !== 3'b000 || busy1 !== 1'b0 || led1 !== 3'b111) begin
      errors++;
      $display("FAIL reset_values_nogap gnt=%b done=%b busy=%b led=%b required 000 000 0 111", gnt1, done1, busy1, led1);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || led !== 3'b111) begin
      errors++;
      $display("FAIL idle_no_req gnt=%b busy=%b led=%b required 000 0 111", gnt, busy, led);
    end
  endtask

  task automatic test_round_robin;
    bit ok;
    int base = starts;
    color = {3'b100, 3'b010, 3'b001};
    ms = {3{16'd1}};
    start_q.delete();
    for (int k = 0; k < 4; k++) expect_rec(3'(1 << (k % 3)), ~color[3*(k%3) +: 3], 4, 8);
    req = 3'b111;
    wait_starts(base + 4, ok);
    req = 3'b000;
    wait_drained(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_timeout pending records remained, required none"); end
    for (int k = 0; k + 1 < start_q.size() && k < 3; k++) begin
      checks++;
      if (start_q[k+1] - start_q[k] != 13) begin
        errors++;
        $display("FAIL rr_spacing grant %0d spacing %0d required 13", k + 1, start_q[k+1] - start_q[k]);
      end
    end
  endtask

  task automatic test_single;
    bit ok;
    int base = starts;
    color = 9'b000_000_001;
    ms = {16'd0, 16'd0, 16'd3};
    expect_rec(3'b001, 3'b110, 12, 8);
    expect_rec(3'b001, 3'b110, 12, 8);
    req = 3'b001;
    wait_starts(base + 2, ok);
    req = 3'b000;
    wait_drained(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout pending records remained, required none"); end
    repeat (20) @(negedge clk);
    checks++;
    if (starts != base + 2) begin
      errors++;
      $display("FAIL single_no_regrant grants %0d required %0d", starts - base, 2);
    end
  endtask

  task automatic test_hold_changes;
    bit ok;
    int base = starts;
    color = 9'b000_010_000;
    ms = {16'd0, 16'd5, 16'd0};
    expect_rec(3'b010, 3'b101, 20, 8);
    req = 3'b010;
    wait_starts(base + 1, ok);
    repeat (5) @(posedge clk);
    #1;
    req = 3'b000;
    color = {3{3'b100}};
    ms = {3{16'd1}};
    wait_drained(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_change_timeout pending records remained, required none"); end
    repeat (10) @(negedge clk);
    checks++;
    if (starts != base + 1) begin
      errors++;
      $display("FAIL hold_change_regrant grants %0d required 1", starts - base);
    end
  endtask

  task automatic test_zero_duration;
    bit ok;
    int base = starts, t = 0, len = 0, c0;
    color = 9'b000_000_100;
    ms = '0;
    expect_rec(3'b001, 3'b011, 4, 8);
    req = 3'b001;
    wait_starts(base + 1, ok);
    req = 3'b000;
    wait_drained(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout pending records remained, required none"); end
    color1 = {3{3'b100}};
    ms1 = '0;
    req1 = 3'b001;
    @(negedge clk);
    while (gnt1 == 3'b000 && t < 50) begin @(negedge clk); t++; end
    c0 = cyc;
    while (gnt1 != 3'b000 && len < 50) begin len++; @(negedge clk); end
    checks++;
    if (len != 4) begin errors++; $display("FAIL nogap_hold_len %0d required 4", len); end
    checks++;
    if (done1 !== 3'b001 || busy1 !== 1'b0 || led1 !== 3'b111) begin
      errors++;
      $display("FAIL nogap_done_idle done=%b busy=%b led=%b required 001 0 111", done1, busy1, led1);
    end
    @(negedge clk);
    checks++;
    if (gnt1 !== 3'b001 || cyc - c0 != 5) begin
      errors++;
      $display("FAIL nogap_spacing gnt=%b spacing %0d required 001 5", gnt1, cyc - c0);
    end
    req1 = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int base = starts;
    color = 9'b000_000_001;
    ms = {16'd0, 16'd0, 16'd5};
    req = 3'b001;
    wait_starts(base + 1, ok);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 3'b000 || led !== 3'b111 || done !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid gnt=%b led=%b done=%b busy=%b required 000 111 000 0", gnt, led, done, busy);
    end
    req = 3'b111;
    color = {3'b100, 3'b010, 3'b001};
    ms = {3{16'd1}};
    exp_q.delete();
    expect_rec(3'b001, 3'b110, 4, 8);
    repeat (2) @(negedge clk);
    base = starts;
    rst_n = 1'b1;
    wait_starts(base + 1, ok);
    req = 3'b000;
    wait_drained(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_regrant_timeout pending records remained, required none"); end
  endtask

  task automatic test_done_pulses;
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL stray_done count %0d required 0", bad_done); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_hold_changes;
    test_zero_duration;
    test_reset_mid;
    test_done_pulses;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
